// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM encoding and SPI mode constants
package spi_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SHIFT = 2'd2} state_t;
  localparam bit CPOL_LOW   = 1'b0;
  localparam bit CPOL_HIGH  = 1'b1;
  localparam bit CPHA_LEAD  = 1'b0;
  localparam bit CPHA_TRAIL = 1'b1;
endpackage

// File: rtl/spi_slave_param_if.sv
// spi_slave_param_if: parallel tx/rx handshake and status bundle of the SPI slave
interface spi_slave_param_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic             rx_overrun;
  logic             tx_underrun;
  logic             busy;
  modport slave (input tx_data, tx_valid, rx_ready,
                 output tx_ready, rx_data, rx_valid, rx_overrun, tx_underrun, busy);
  modport master (output tx_data, tx_valid, rx_ready,
                  input tx_ready, rx_data, rx_valid, rx_overrun, tx_underrun, busy);
endinterface

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchroniser with rise/fall pulse detection
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2,
  parameter bit RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic prev_q, prev_d;
  // shift the async input down the chain and remember the last synchronised value
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
    prev_d = sync_q[SYNC_STAGES-1];
  end
  // reset to the idle level so release never looks like an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end
  assign q    = sync_q[SYNC_STAGES-1];
  assign rise = q & ~prev_q;
  assign fall = ~q & prev_q;
endmodule

// File: rtl/spi_slave_param.sv
// spi_slave_param: parameterised SPI slave with tx holding register and rx handshake
module spi_slave_param import spi_pkg::*; #(
  parameter int WIDTH       = 8,
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b0,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sck,
  input  logic mosi,
  input  logic ssel,
  output logic miso,
  output logic miso_oe,
  spi_slave_param_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  logic sck_s, sck_rise, sck_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic ssel_s, ssel_rise, ssel_fall;
  logic lead, trail, sample_e, shift_e, done, reload;
  logic [WIDTH-1:0] word;
  logic unused_edges;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rx_shift_q, rx_shift_d, tx_shift_q, tx_shift_d;
  logic [WIDTH-1:0] hold_q, hold_d, rx_data_q, rx_data_d;
  logic hold_full_q, hold_full_d, rx_valid_q, rx_valid_d;
  logic ovr_q, ovr_d, und_q, und_d, skip_q, skip_d, miso_q, miso_d;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sck (
    .clk(clk), .rst_n(rst_n), .d(sck), .q(sck_s), .rise(sck_rise), .fall(sck_fall));
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .clk(clk), .rst_n(rst_n), .d(mosi), .q(mosi_s), .rise(mosi_rise), .fall(mosi_fall));
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ssel (
    .clk(clk), .rst_n(rst_n), .d(ssel), .q(ssel_s), .rise(ssel_rise), .fall(ssel_fall));

  assign unused_edges = ^{mosi_rise, mosi_fall, ssel_rise, sck_s};
  assign lead     = (CPOL == CPOL_LOW) ? sck_rise : sck_fall;
  assign trail    = (CPOL == CPOL_LOW) ? sck_fall : sck_rise;
  assign sample_e = (CPHA == CPHA_LEAD) ? lead : trail;
  assign shift_e  = (CPHA == CPHA_LEAD) ? trail : lead;
  assign word     = {rx_shift_q[WIDTH-2:0], mosi_s};
  assign done     = (state_q == SHIFT) && sample_e && (cnt_q == CW'(WIDTH-1));
  assign reload   = (state_q == LOAD) || done;

  // next-state: frame FSM, shifters, holding register and rx handshake
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q & ~bus.rx_ready;
    ovr_d       = 1'b0;
    und_d       = 1'b0;
    skip_d      = skip_q;
    if (state_q == IDLE && ssel_fall) state_d = LOAD;
    if (state_q == LOAD) begin
      state_d = SHIFT;
      skip_d  = (CPHA == CPHA_TRAIL);
    end
    if (state_q == SHIFT && sample_e) begin
      rx_shift_d = word;
      cnt_d      = done ? '0 : cnt_q + 1'b1;
    end
    // the first shift edge after a (re)load only exposes the new MSB
    if (state_q == SHIFT && shift_e) begin
      tx_shift_d = skip_q ? tx_shift_q : tx_shift_q << 1;
      skip_d     = 1'b0;
    end
    if (done) begin
      skip_d = 1'b1;
      if (!rx_valid_q || bus.rx_ready) begin
        rx_data_d  = word;
        rx_valid_d = 1'b1;
      end else ovr_d = 1'b1;
    end
    if (reload) begin
      tx_shift_d  = hold_full_q ? hold_q : '0;
      hold_full_d = 1'b0;
      und_d       = ~hold_full_q;
    end
    // a write lands after any reload so it refills a just-emptied register
    if (bus.tx_valid && !hold_full_q) begin
      hold_d      = bus.tx_data;
      hold_full_d = 1'b1;
    end
    // deselect aborts the frame but keeps the holding register
    if (ssel_s) begin
      state_d    = IDLE;
      cnt_d      = '0;
      rx_shift_d = '0;
      tx_shift_d = '0;
      skip_d     = 1'b0;
    end
    miso_d = (state_d == IDLE) ? 1'b0 :
             ((CPHA == CPHA_LEAD) || (state_q == SHIFT && shift_e)) ? tx_shift_d[WIDTH-1] : miso_q;
  end

  // state and registered outputs, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      ovr_q       <= 1'b0;
      und_q       <= 1'b0;
      skip_q      <= 1'b0;
      miso_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      ovr_q       <= ovr_d;
      und_q       <= und_d;
      skip_q      <= skip_d;
      miso_q      <= miso_d;
    end
  end

  assign miso            = miso_q;
  assign miso_oe         = (state_q != IDLE);
  assign bus.busy        = (state_q == SHIFT);
  assign bus.tx_ready    = ~hold_full_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.rx_overrun  = ovr_q;
  assign bus.tx_underrun = und_q;
endmodule

// File: tb/tb_spi_slave_param.sv
// tb_spi_slave_param: directed checks of the SPI slave in all four modes and at WIDTH=16
module tb_spi_slave_param;
  localparam int H = 8;
  localparam logic [4:0] CPOL_V = 5'b01100;
  localparam logic [4:0] CPHA_V = 5'b01010;
  logic clk = 1'b0, rst_n = 1'b0, mosi = 1'b0;
  logic [4:0] sck = CPOL_V, ssel = '1, txv = '0, rxr = '1;
  logic [31:0] txd [5];
  wire [4:0] miso_w, oe_w, busy_w, txr_w, rxv_w, ovr_w, und_w;
  wire [31:0] rxd_w [5];
  int rxv_n [5], ovr_n [5], und_n [5];
  logic [31:0] rx_last [5], rx_prev [5];
  logic [4:0] rxv_q = '0;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 5; g++) begin : u
    localparam int W = (g == 4) ? 16 : 8;
    spi_slave_param_if #(.WIDTH(W)) bus ();
    spi_slave_param #(.WIDTH(W), .CPOL(CPOL_V[g]), .CPHA(CPHA_V[g]), .SYNC_STAGES(g == 3 ? 3 : 2)) dut (
      .clk(clk), .rst_n(rst_n), .sck(sck[g]), .mosi(mosi), .ssel(ssel[g]),
      .miso(miso_w[g]), .miso_oe(oe_w[g]), .bus(bus));
    assign bus.tx_data  = txd[g][W-1:0];
    assign bus.tx_valid = txv[g];
    assign bus.rx_ready = rxr[g];
    assign rxd_w[g]  = 32'(bus.rx_data);
    assign rxv_w[g]  = bus.rx_valid;
    assign txr_w[g]  = bus.tx_ready;
    assign ovr_w[g]  = bus.rx_overrun;
    assign und_w[g]  = bus.tx_underrun;
    assign busy_w[g] = bus.busy;
  end

  // count rx_valid rises and error pulses, keep the last two received words
  always @(posedge clk) begin
    for (int i = 0; i < 5; i++) begin
      if (rxv_w[i] && !rxv_q[i]) begin
        rxv_n[i]   <= rxv_n[i] + 1;
        rx_prev[i] <= rx_last[i];
        rx_last[i] <= rxd_w[i];
      end
      if (ovr_w[i]) ovr_n[i] <= ovr_n[i] + 1;
      if (und_w[i]) und_n[i] <= und_n[i] + 1;
    end
    rxv_q <= rxv_w;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic push(input int i, input logic [31:0] d);
    txd[i] = d;
    txv[i] = 1'b1;
    for (int k = 0; k < 2000 && !txr_w[i]; k++) @(negedge clk);
    checks++;
    if (!txr_w[i]) begin failures++; $display("FAIL push_ready inst=%0d got=0 want=1", i); end
    @(negedge clk);
    txv[i] = 1'b0;
  endtask

  task automatic frame_begin(input int i);
    ssel[i] = 1'b0;
    repeat (H) @(negedge clk);
  endtask

  task automatic frame_end(input int i);
    repeat (H) @(negedge clk);
    ssel[i] = 1'b1;
    repeat (2 * H) @(negedge clk);
  endtask

  task automatic word(input int i, input int w, input logic [31:0] tx, input int nbits, output logic [31:0] rx);
    rx = '0;
    for (int k = 0; k < nbits; k++) begin
      if (!CPHA_V[i]) begin
        mosi = tx[w-1-k];
        repeat (H) @(negedge clk);
        sck[i] = ~CPOL_V[i];
        rx = {rx[30:0], miso_w[i]};
        repeat (H) @(negedge clk);
        sck[i] = CPOL_V[i];
      end else begin
        sck[i] = ~CPOL_V[i];
        mosi = tx[w-1-k];
        repeat (H) @(negedge clk);
        sck[i] = CPOL_V[i];
        rx = {rx[30:0], miso_w[i]};
        repeat (H) @(negedge clk);
      end
    end
  endtask

  task automatic test_reset;
    for (int i = 0; i < 5; i++) txd[i] = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({miso_w[i], oe_w[i], busy_w[i], txr_w[i], rxv_w[i], rxd_w[i]} !== {5'b00010, 32'h0}) begin
        failures++;
        $display("FAIL reset_state inst=%0d got=%b_%h want=00010_00000000", i,
                 {miso_w[i], oe_w[i], busy_w[i], txr_w[i], rxv_w[i]}, rxd_w[i]);
      end
    end
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if ({busy_w, oe_w, und_w} !== 15'h0) begin
      failures++;
      $display("FAIL reset_release busy/oe/und got=%b want=0", {busy_w, oe_w, und_w});
    end
  endtask

  task automatic test_mode0;
    logic [31:0] r;
    int nv, nu;
    push(0, 32'hA5);
    checks++;
    if (txr_w[0] !== 1'b0) begin failures++; $display("FAIL mode0_tx_ready_full got=%b want=0", txr_w[0]); end
    nv = rxv_n[0];
    nu = und_n[0];
    frame_begin(0);
    checks++;
    if ({busy_w[0], oe_w[0]} !== 2'b11) begin failures++; $display("FAIL mode0_busy_oe got=%b want=11", {busy_w[0], oe_w[0]}); end
    word(0, 8, 32'h3C, 8, r);
    frame_end(0);
    checks++;
    if (r !== 32'hA5) begin failures++; $display("FAIL mode0_master_rx got=%h want=a5", r); end
    checks++;
    if (rxd_w[0] !== 32'h3C) begin failures++; $display("FAIL mode0_rx_data got=%h want=3c", rxd_w[0]); end
    checks++;
    if (rxv_n[0] - nv !== 1) begin failures++; $display("FAIL mode0_rx_valid_count got=%0d want=1", rxv_n[0] - nv); end
    checks++;
    if (und_n[0] - nu !== 1) begin failures++; $display("FAIL mode0_end_underrun got=%0d want=1", und_n[0] - nu); end
    checks++;
    if ({busy_w[0], oe_w[0], miso_w[0]} !== 3'b000) begin
      failures++;
      $display("FAIL mode0_idle_after got=%b want=000", {busy_w[0], oe_w[0], miso_w[0]});
    end
  endtask

  task automatic test_modes;
    logic [31:0] r;
    int nv;
    for (int m = 1; m < 4; m++) begin
      push(m, 32'h7E);
      nv = rxv_n[m];
      frame_begin(m);
      word(m, 8, 32'h81, 8, r);
      frame_end(m);
      checks++;
      if (r !== 32'h7E) begin failures++; $display("FAIL mode%0d_master_rx got=%h want=7e", m, r); end
      checks++;
      if (rxv_n[m] - nv !== 1 || rx_last[m] !== 32'h81) begin
        failures++;
        $display("FAIL mode%0d_slave_rx got=%h count=%0d want=81 count=1", m, rx_last[m], rxv_n[m] - nv);
      end
    end
  endtask

  task automatic test_width16;
    logic [31:0] r0, r1;
    int nv, nu;
    push(4, 32'h1234);
    nv = rxv_n[4];
    nu = und_n[4];
    fork
      begin
        frame_begin(4);
        word(4, 16, 32'h1234, 16, r0);
        word(4, 16, 32'hBEEF, 16, r1);
        frame_end(4);
      end
      begin
        push(4, 32'hBEEF);
        push(4, 32'h0000);
      end
    join
    checks++;
    if ({r0[15:0], r1[15:0]} !== 32'h1234BEEF) begin
      failures++;
      $display("FAIL w16_master_rx got=%h_%h want=1234_beef", r0[15:0], r1[15:0]);
    end
    checks++;
    if (rxv_n[4] - nv !== 2 || rx_prev[4] !== 32'h1234 || rx_last[4] !== 32'hBEEF) begin
      failures++;
      $display("FAIL w16_slave_rx got=%h_%h count=%0d want=1234_beef count=2", rx_prev[4], rx_last[4], rxv_n[4] - nv);
    end
    checks++;
    if (und_n[4] - nu !== 0) begin failures++; $display("FAIL w16_underrun got=%0d want=0", und_n[4] - nu); end
  endtask

  task automatic test_overrun;
    logic [31:0] r0, r1;
    int no, nu;
    rxr[0] = 1'b0;
    no = ovr_n[0];
    nu = und_n[0];
    frame_begin(0);
    word(0, 8, 32'h11, 8, r0);
    word(0, 8, 32'h22, 8, r1);
    frame_end(0);
    checks++;
    if ({rxv_w[0], rxd_w[0]} !== {1'b1, 32'h11}) begin
      failures++;
      $display("FAIL ovr_rx_data got=%b_%h want=1_11", rxv_w[0], rxd_w[0]);
    end
    checks++;
    if (ovr_n[0] - no !== 1) begin failures++; $display("FAIL ovr_pulse_count got=%0d want=1", ovr_n[0] - no); end
    checks++;
    if (und_n[0] - nu !== 3) begin failures++; $display("FAIL und_pulse_count got=%0d want=3", und_n[0] - nu); end
    checks++;
    if ({r0, r1} !== 64'h0) begin failures++; $display("FAIL und_master_rx got=%h_%h want=0_0", r0, r1); end
    rxr[0] = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (rxv_w[0] !== 1'b0) begin failures++; $display("FAIL ovr_rx_valid_clear got=%b want=0", rxv_w[0]); end
  endtask

  task automatic test_partial;
    logic [31:0] r;
    int nv;
    nv = rxv_n[0];
    frame_begin(0);
    word(0, 8, 32'hFF, 5, r);
    frame_end(0);
    checks++;
    if (rxv_n[0] - nv !== 0 || busy_w[0] !== 1'b0) begin
      failures++;
      $display("FAIL partial_no_valid got=count%0d busy%b want=count0 busy0", rxv_n[0] - nv, busy_w[0]);
    end
    frame_begin(0);
    word(0, 8, 32'h55, 8, r);
    frame_end(0);
    checks++;
    if (rxv_n[0] - nv !== 1 || rx_last[0] !== 32'h55 || rxd_w[0] !== 32'h55) begin
      failures++;
      $display("FAIL partial_next_word got=%h count=%0d want=55 count=1", rxd_w[0], rxv_n[0] - nv);
    end
  endtask

  task automatic test_reset_midframe;
    logic [31:0] r;
    push(0, 32'hA5);
    frame_begin(0);
    word(0, 8, 32'h3C, 3, r);
    checks++;
    if (busy_w[0] !== 1'b1) begin failures++; $display("FAIL midframe_busy got=%b want=1", busy_w[0]); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({miso_w[0], oe_w[0], busy_w[0], txr_w[0], rxv_w[0], ovr_w[0], und_w[0], rxd_w[0]} !== {7'b0001000, 32'h0}) begin
      failures++;
      $display("FAIL async_reset got=%b_%h want=0001000_00000000",
               {miso_w[0], oe_w[0], busy_w[0], txr_w[0], rxv_w[0], ovr_w[0], und_w[0]}, rxd_w[0]);
    end
    ssel[0] = 1'b1;
    sck[0] = CPOL_V[0];
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    test_mode0();
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_modes();
    test_width16();
    test_overrun();
    test_partial();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spi_slave_param.md
SPI_SLAVE_PARAM -- requirements
Module: spi_slave_param

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the SPI word length in bits (legal 4..32).
REQ-002 SHALL have parameter CPOL, default 0, giving the SCK idle level.
REQ-003 SHALL have parameter CPHA, default 0: 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-004 SHALL have parameter SYNC_STAGES, default 2, giving the synchroniser depth on sck/mosi/ssel (legal 2..3).
REQ-005 clk  input  1  system clock (sysclk from the PLL); all logic on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 sck  input  1  SPI clock from master, asynchronous to clk.
REQ-008 mosi  input  1  serial data from master, MSB first.
REQ-009 ssel  input  1  slave select, active low.
REQ-010 miso  output  1  serial data to master, MSB first.
REQ-011 miso_oe  output  1  high while ssel is synchronised-active; the top level tristates miso when low.
REQ-012 tx_data  input  WIDTH  next word to transmit.
REQ-013 tx_valid / tx_ready  input / output  1 each  tx handshake; the word is accepted on the cycle both are high.
REQ-014 rx_data  output  WIDTH  last complete received word.
REQ-015 rx_valid / rx_ready  output / input  1 each  rx handshake; the word is consumed on the cycle both are high.
REQ-016 rx_overrun, tx_underrun  output  1 each  one-cycle error pulses.
REQ-017 busy  output  1  high while a frame is active (state SHIFT).

Function
REQ-018 sck, mosi and ssel SHALL each pass through SYNC_STAGES flops; edges SHALL be detected on the synchronised sck; the supported range is f_sck <= f_clk/8.
REQ-019 Leading edge = synchronised sck leaving CPOL; trailing edge = returning to CPOL; sample edge = leading if CPHA=0, else trailing; shift edge = the other one.
REQ-020 FSM states: IDLE, LOAD, SHIFT. IDLE->LOAD on synchronised ssel falling; LOAD->SHIFT after exactly one cycle; SHIFT->IDLE on synchronised ssel rising; any state->IDLE when ssel is synchronised-high.
REQ-021 In LOAD: if the holding register is full, copy it to the tx shift register and mark it empty; otherwise load all-zeros and pulse tx_underrun.
REQ-022 miso SHALL present the shift-register MSB; CPHA=0: valid from LOAD onward; CPHA=1: updated on the first shift edge.
REQ-023 On each sample edge: rx shift register <= {rx_shift[WIDTH-2:0], mosi}; bit counter +1.
REQ-024 On each shift edge (excluding the CPHA=1 first leading edge): tx shift left by one, zero fill.
REQ-025 When the counter reaches WIDTH: counter wraps to 0; the completed word transfers to rx_data with rx_valid=1 one clk after the sample-edge detection; the holding register reloads the tx shift register as in REQ-021, so back-to-back words need no ssel toggle.
REQ-026 If rx_valid is still high when a new word completes: the new word is dropped, rx_data is unchanged, and rx_overrun pulses for one cycle.
REQ-027 rx_valid SHALL stay high until rx_ready; when both are high in the same cycle as a completion, the new word is accepted with no overrun.
REQ-028 tx_ready = holding register empty; a write accepted in the same cycle as a reload SHALL fill the just-emptied holding register.
REQ-029 ssel deasserted mid-word: partial rx bits discarded, no rx_valid, counter cleared, holding register contents retained.
REQ-030 busy = (state == SHIFT); miso_oe = (state != IDLE).

Reset
REQ-031 rst_n low SHALL asynchronously set: state IDLE, counter 0, both shift registers 0, holding register empty, rx_data 0, rx_valid 0, tx_ready 1, errors 0, busy 0, miso 0, miso_oe 0, and synchroniser flops for sck=CPOL and ssel=1.
REQ-032 Reset release SHALL NOT generate a spurious edge or frame start.

Structure
REQ-033 The state encoding and the CPOL/CPHA mode constants SHALL reside in package spi_pkg.
REQ-034 The synchroniser plus edge detector SHALL be sub-module spi_sync_edge (parameter SYNC_STAGES), instantiated once per input; sck exports rise/fall pulses.

Verification
REQ-035 Mode 0, WIDTH=8: tx 0xA5 preloaded, master sends 0x3C -> master reads 0xA5; rx_data=0x3C with a single rx_valid.
REQ-036 Modes 1, 2 and 3 each: master sends 0x81 while slave sends 0x7E -> both ends exchange their words bit-exactly.
REQ-037 WIDTH=16: two words, 0x1234 then 0xBEEF, in one ssel frame with tx_data refilled -> both received in order; no underrun.
REQ-038 rx_ready held low across two words -> rx_data=first word, one rx_overrun pulse; tx not preloaded -> master reads 0x00 and tx_underrun pulses.
REQ-039 ssel raised after 5 of 8 bits, then a full frame sends 0x55 -> no rx_valid for the partial word; the next rx_data=0x55.
REQ-040 rst_n asserted mid-frame -> all outputs reach their reset values with no clk edge; a following frame behaves exactly as in REQ-035.
